// File: rtl/calc_pkg.sv
// calc_pkg: op/format codes, FSM states and display limit shared by the calculator ALU
package calc_pkg;
    typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3} op_t;
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FMT} state_t;
    localparam logic [2:0] CONTR_POS = 3'd0;
    localparam logic [2:0] CONTR_NEG = 3'd1;
    localparam logic [2:0] CONTR_ERR = 3'd2;
    localparam logic [2:0] CONTR_FIX = 3'd4;
    function automatic logic [31:0] max_disp(input int unsigned ind);
        return ((32'd1 << ind) - 32'd1 < 32'd9999) ? (32'd1 << ind) - 32'd1 : 32'd9999;
    endfunction
endpackage

// File: rtl/calc_div_seq.sv
// calc_div_seq: restoring divider, one quotient bit per step, MSB first
// Ports: i_load captures dividend/divisor, i_step runs one step, o_ready is high
//        during the final step, o_quot is the quotient once that step is taken.
module calc_div_seq #(
    parameter int DW = 15,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic          i_step,
    input  logic [DW-1:0] i_dividend,
    input  logic [VW-1:0] i_divisor,
    output logic          o_ready,
    output logic [DW-1:0] o_quot
);
    localparam int CW = $clog2(DW);
    logic [VW-1:0] r_rem;
    logic [DW-1:0] r_quo;
    logic [VW-1:0] r_dvs;
    logic [CW-1:0] r_cnt;
    logic [VW:0]   w_shift;
    logic          w_fit;
    // remainder stays below the divisor, so VW bits hold it between steps
    assign w_shift = {r_rem, r_quo[DW-1]};
    assign w_fit   = w_shift >= {1'b0, r_dvs};
    assign o_ready = r_cnt == '0;
    assign o_quot  = r_quo;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_dvs <= i_divisor;
            r_cnt <= CW'(DW - 1);
        end else if (i_step) begin
            r_rem <= w_fit ? VW'(w_shift - {1'b0, r_dvs}) : w_shift[VW-1:0];
            r_quo <= {r_quo[DW-2:0], w_fit};
            r_cnt <= o_ready ? r_cnt : r_cnt - CW'(1);
        end
    end
endmodule

// File: rtl/calc_alu_seq.sv
// calc_alu_seq: multi-cycle add/sub/mul/div feeding the 7-segment display driver
// Ports: i_start/i_a/i_b/i_op request, o_busy/o_done status, o_data magnitude, o_contr format.
// Build option CALC_DIV_ROUND_EN: round-half-up of the x.xx division result.
import calc_pkg::*;
module calc_alu_seq #(
    parameter int OP_W    = 8,
    parameter int IND_ALU = 11,
    parameter int C_ALU   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [OP_W-1:0]    i_a,
    input  logic [OP_W-1:0]    i_b,
    input  logic [1:0]         i_op,
    output logic               o_busy,
    output logic               o_done,
    output logic [IND_ALU-1:0] o_data,
    output logic [C_ALU-1:0]   o_contr
);
    localparam int          DW       = OP_W + 7;
    localparam int          CW       = $clog2(OP_W);
    localparam logic [31:0] MAX_DISP = max_disp(IND_ALU);
    state_t             r_state, w_state_nxt;
    op_t                r_op;
    logic [OP_W-1:0]    r_a, r_b, r_mplier;
    logic [2*OP_W-1:0]  r_acc, r_mcand;
    logic [CW-1:0]      r_cnt;
    logic               r_done;
    logic [IND_ALU-1:0] r_data, w_data;
    logic [C_ALU-1:0]   r_contr, w_contr;
    logic               w_accept, w_div_ready, w_neg;
    logic [DW-1:0]      w_dividend, w_quo;
    logic [OP_W:0]      w_sum;
    logic [OP_W-1:0]    w_mag;
    assign w_accept = r_state == S_IDLE && i_start;
`ifdef CALC_DIV_ROUND_EN
    assign w_dividend = DW'(i_a) * DW'(100) + DW'(i_b >> 1);
`else
    assign w_dividend = DW'(i_a) * DW'(100);
`endif
    calc_div_seq #(.DW(DW), .VW(OP_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_accept && i_op == OP_DIV),
        .i_step    (r_state == S_DIV),
        .i_dividend(w_dividend),
        .i_divisor (i_b),
        .o_ready   (w_div_ready),
        .o_quot    (w_quo)
    );
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_state_nxt = i_op == OP_MUL ? S_MUL :
                                               (i_op == OP_DIV && i_b != '0) ? S_DIV : S_FMT;
            S_MUL:  if (r_cnt == '0) w_state_nxt = S_FMT;
            S_DIV:  if (w_div_ready) w_state_nxt = S_FMT;
            S_FMT:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end
    assign w_sum = {1'b0, r_a} + {1'b0, r_b};
    assign w_neg = r_a < r_b;
    assign w_mag = w_neg ? r_b - r_a : r_a - r_b;
    always_comb begin
        w_data  = '0;
        w_contr = C_ALU'(CONTR_ERR);
        case (r_op)
            OP_ADD: if (32'(w_sum) <= MAX_DISP) begin
                w_data  = IND_ALU'(w_sum);
                w_contr = C_ALU'(CONTR_POS);
            end
            OP_SUB: if (!w_neg || 32'(w_mag) <= 32'd999) begin
                w_data  = IND_ALU'(w_mag);
                w_contr = w_neg ? C_ALU'(CONTR_NEG) : C_ALU'(CONTR_POS);
            end
            OP_MUL: if (32'(r_acc) <= MAX_DISP) begin
                w_data  = IND_ALU'(r_acc);
                w_contr = C_ALU'(CONTR_POS);
            end
            // too large for x.xx: fall back to the integer part of the scaled quotient
            OP_DIV: if (r_b != '0) begin
                w_data  = 32'(w_quo) <= MAX_DISP ? IND_ALU'(w_quo) : IND_ALU'(w_quo / DW'(100));
                w_contr = 32'(w_quo) <= MAX_DISP ? C_ALU'(CONTR_FIX) : C_ALU'(CONTR_POS);
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_data   <= '0;
            r_contr  <= '0;
        end else begin
            r_done <= r_state == S_FMT;
            if (w_accept) begin
                r_op     <= op_t'(i_op);
                r_a      <= i_a;
                r_b      <= i_b;
                r_mplier <= i_b;
                r_mcand  <= (2*OP_W)'(i_a);
                r_acc    <= '0;
                r_cnt    <= CW'(OP_W - 1);
            end
            if (r_state == S_MUL) begin
                r_acc    <= r_mplier[0] ? r_acc + r_mcand : r_acc;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt - CW'(1);
            end
            if (r_state == S_FMT) begin
                r_data  <= w_data;
                r_contr <= w_contr;
            end
        end
    end
    assign o_busy  = r_state != S_IDLE || r_done;
    assign o_done  = r_done;
    assign o_data  = r_data;
    assign o_contr = r_contr;
endmodule

// File: tb/tb_calc_alu_seq.sv
// tb_calc_alu_seq: scoreboard bench for calc_alu_seq
module tb_calc_alu_seq;
`ifdef CALC_DIV_ROUND_EN
    localparam int ROUND = 1;
`else
    localparam int ROUND = 0;
`endif
    logic        clk = 1'b0, rst = 1'b1, i_start = 1'b0;
    logic [7:0]  i_a = '0, i_b = '0;
    logic [1:0]  i_op = '0;
    logic        o_busy, o_done;
    logic [10:0] o_data;
    logic [2:0]  o_contr;
    int          checks = 0, failures = 0, cyc = 0;
    typedef struct {string tag; int data; int contr; int cyc;} exp_t;
    exp_t sb[$];
    calc_alu_seq dut (
        .clk    (clk),
        .rst    (rst),
        .i_start(i_start),
        .i_a    (i_a),
        .i_b    (i_b),
        .i_op   (i_op),
        .o_busy (o_busy),
        .o_done (o_done),
        .o_data (o_data),
        .o_contr(o_contr)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    function automatic void model(input int a, input int b, input int op,
                                  output int d, output int c, output int lat);
        int q;
        lat = 2;
        d   = 0;
        c   = 2;
        case (op)
            0: if (a + b <= 2047) begin d = a + b; c = 0; end
            1: if (a >= b) begin d = a - b; c = 0; end
               else if (b - a <= 999) begin d = b - a; c = 1; end
            2: begin
                lat = 10;
                if (a * b <= 2047) begin d = a * b; c = 0; end
            end
            default: if (b != 0) begin
                lat = 17;
                q = (a * 100 + (ROUND != 0 ? b / 2 : 0)) / b;
                if (q <= 2047) begin d = q; c = 4; end
                else begin d = a / b; c = 0; end
            end
        endcase
    endfunction
    always @(negedge clk) begin
        exp_t e;
        if (!rst && o_done) begin
            if (sb.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                e = sb.pop_front();
                chk({e.tag, "_data"}, int'(o_data), e.data);
                chk({e.tag, "_contr"}, int'(o_contr), e.contr);
                chk({e.tag, "_lat"}, cyc, e.cyc);
            end
        end
    end
    task automatic go(input string tag, input int a, input int b, input int op,
                      input int ed, input int ec, input int lat);
        exp_t e;
        @(negedge clk);
        i_a     = 8'(a);
        i_b     = 8'(b);
        i_op    = 2'(op);
        i_start = 1'b1;
        e.tag   = tag;
        e.data  = ed;
        e.contr = ec;
        e.cyc   = cyc + lat;
        sb.push_back(e);
        @(negedge clk);
        i_start = 1'b0;
    endtask
    task automatic drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask
    initial begin
        int n, a, b, op, d, c, l;
        repeat (3) @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_data", int'(o_data), 0);
        chk("rst_contr", int'(o_contr), 0);
        rst = 1'b0;
        go("add_200_150", 200, 150, 0, 350, 0, 2);
        chk("add_busy_n1", o_busy, 1);
        @(negedge clk);
        chk("add_busy_n2", o_busy, 1);
        @(negedge clk);
        chk("add_busy_n3", o_busy, 0);
        chk("add_done_n3", o_done, 0);
        go("sub_5_9", 5, 9, 1, 4, 1, 2);
        go("add_255_255_b2b", 255, 255, 0, 510, 0, 2);
        drain();
        go("mul_12_34", 12, 34, 2, 408, 0, 10);
        drain();
        go("mul_255_255", 255, 255, 2, 0, 2, 10);
        drain();
        go("div_7_2", 7, 2, 3, 350, 4, 17);
        drain();
        go("div_5_0", 5, 0, 3, 0, 2, 2);
        drain();
        go("div_200_3", 200, 3, 3, 66, 0, 17);
        drain();
        go("div_2_3", 2, 3, 3, ROUND != 0 ? 67 : 66, 4, 17);
        drain();
        @(negedge clk);
        i_a     = 8'd100;
        i_b     = 8'd7;
        i_op    = 2'd3;
        i_start = 1'b1;
        n       = cyc;
        @(negedge clk);
        i_start = 1'b0;
        while (cyc < n + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", o_busy, 0);
        chk("abort_done", o_done, 0);
        chk("abort_data", int'(o_data), 0);
        chk("abort_contr", int'(o_contr), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_idle_busy", o_busy, 0);
        go("mul_3_3_collide", 3, 3, 2, 9, 0, 10);
        repeat (2) @(negedge clk);
        i_a     = 8'd1;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        drain();
        d = 0;
        c = 0;
        for (int i = 0; i < 16; i++) begin
            a  = $urandom_range(0, 255);
            b  = $urandom_range(0, 255);
            op = $urandom_range(0, 3);
            model(a, b, op, d, c, l);
            go($sformatf("rnd%0d_op%0d_%0d_%0d", i, op, a, b), a, b, op, d, c, l);
            drain();
        end
        repeat (4) @(negedge clk);
        chk("hold_data", int'(o_data), d);
        chk("hold_contr", int'(o_contr), c);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/calc_alu_seq.md
Name: calc_alu_seq

Overview:
- Sequential arithmetic stage of the calculator; sits directly upstream of the 7-segment display driver.
- Takes two unsigned operands and an op code, computes add/sub/mul/div over multiple cycles and produces the display driver's inputs: binary magnitude `data` and format code `contr`.
- Multiply uses shift-add; divide uses restoring division.
- Division yields a 2-decimal fixed-point result that the display shows with the dot on digit 3.

Parameters:
- OP_W, 8, operand width (unsigned).
- IND_ALU, 11, width of `data` output; must match the display driver.
- C_ALU, 3, width of `contr` output; must match the display driver.
- MAX_DISP, derived = min(2^IND_ALU-1, 9999) = 2047, largest displayable magnitude.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  request; sampled only in IDLE
- a  in  OP_W  operand A
- b  in  OP_W  operand B
- op  in  2  operation: 00 add, 01 sub, 10 mul, 11 div
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse; data/contr updated in the same cycle
- data  out  IND_ALU  result magnitude
- contr  out  C_ALU  format: 0 positive, 1 negative, 2 error, 4 fixed-point x.xx

Behaviour:
- One clock `clk`. Reset `rst` is synchronous, active-high.
- Reset values: state=IDLE, busy=0, done=0, data=0, contr=0. Reset mid-operation aborts immediately; no done is issued.
- States: IDLE, MUL, DIV, FMT.
- Operand capture: start=1 in IDLE at cycle N latches a, b, op. The next state is:
  - FMT for add/sub, and for div with b=0.
  - MUL for mul, running OP_W cycles.
  - DIV for div, running OP_W+7 cycles.
- busy is high from cycle N+1 through the cycle done is high.
- start while busy is ignored; operands are held internally.
- FMT lasts one cycle and registers data/contr. done=1 in the following cycle; state returns to IDLE in that cycle, so back-to-back start is accepted in the done cycle.
- Latency (done cycle relative to start cycle N), OP_W=8:
  - add/sub/div-by-zero: N+2
  - mul: N+OP_W+2 = N+10
  - div: N+OP_W+9 = N+17
- data/contr hold until the next done or reset.
- Add: s=a+b. If s<=MAX_DISP: data=s, contr=0. Otherwise data=0, contr=2.
- Sub: if a>=b, data=a-b, contr=0. Else m=b-a; if m<=999, data=m, contr=1; otherwise data=0, contr=2.
- Mul: p (2*OP_W bits), computed by shift-add, one partial product per cycle, LSB first. If p<=MAX_DISP: data=p, contr=0. Otherwise data=0, contr=2.
- Div, b=0: data=0, contr=2.
- Div, b!=0: dividend D=a*100 (OP_W+7 bits); quotient q=D/b by restoring division, one bit per cycle, MSB first.
  - If q<=MAX_DISP: data=q, contr=4.
  - Else: data=a/b (integer, taken from q/100 computed in FMT by a constant-divisor truncation), contr=0.
- All widths unsigned; no truncation is allowed before the MAX_DISP comparison.

Optional Feature:
- Macro: CALC_DIV_ROUND_EN.
- Defined: fixed-point dividend becomes D=a*100+floor(b/2), giving round-half-up of the scaled quotient. The integer fallback path stays truncated.
- Undefined: pure truncation. Latency is unchanged in both cases.

Decomposition:
- Package calc_pkg:
  - op codes: OP_ADD, OP_SUB, OP_MUL, OP_DIV
  - contr codes: CONTR_POS=0, CONTR_NEG=1, CONTR_ERR=2, CONTR_FIX=4
  - state enum
  - MAX_DISP function
- One sub-module: calc_div_seq, the restoring divider with load/step/ready signals. The FSM, multiplier and FMT logic stay in calc_alu_seq.

Test Plan:
- add a=200, b=150, start at N -> done at N+2, data=350, contr=0; busy high N+1..N+2.
- sub a=5, b=9 -> data=4, contr=1. Then add a=255, b=255 -> data=510, contr=0.
- mul a=12, b=34 -> done N+10, data=408, contr=0. mul a=255, b=255 -> data=0, contr=2.
- div a=7, b=2 -> done N+17, data=350, contr=4.
  - div a=200, b=3 -> data=66, contr=0 (fallback).
  - div a=2, b=3 -> data=66, contr=4 without the macro; data=67 with CALC_DIV_ROUND_EN.
- div a=5, b=0 -> done N+2, data=0, contr=2.
- Abort and collision: start div, assert rst at N+5 -> no done, all outputs 0, state IDLE.
  - Restart mul a=3, b=3.
  - Pulse start with a=1 at N+3 while busy -> ignored; data=9, contr=0.
